// File: rtl/fp_pkg.sv
// Shared binary32 types, constants and classification helper for the fp_add pipeline.
// FP_ADD_LAT supplies the default issue-to-result latency when not provided by the build.
`ifndef FP_ADD_LAT
`define FP_ADD_LAT 3
`endif

package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
  } fp_class_t;

  localparam int unsigned FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;

  // S1 -> S2: operands swapped so ma holds the larger magnitude, mb already aligned
  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        zero;
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [26:0] ma;
    logic [26:0] mb;
  } s1_t;

  // S2 -> S3: normalized mantissa with guard and sticky
  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        zero;
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        g;
    logic        st;
  } s2_t;

  function automatic fp_class_t classify(input fp32_t x);
    fp_class_t c;
    c.zero = (x.exp == 8'd0) && (x.frac == 23'd0);
    c.sub  = (x.exp == 8'd0) && (x.frac != 23'd0);
    c.inf  = (x.exp == 8'hFF) && (x.frac == 23'd0);
    c.nan  = (x.exp == 8'hFF) && (x.frac != 23'd0);
    return c;
  endfunction

endpackage

// File: rtl/fp_add_lzc.sv
// Combinational 28-bit leading-zero counter for the S2 normalizer; all-zero input gives 28.
module fp_lzc (
  input  logic [27:0] in_i,
  output logic [4:0]  cnt_o
);

  always_comb begin
    cnt_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (in_i[i]) cnt_o = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_add.sv
// Pipelined binary32 adder/subtractor, fixed latency LAT, no stall and no output valid.
// Define FP_ADD_DENORM_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fp_add
  import fp_pkg::*;
#(
  parameter int unsigned LAT = `FP_ADD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        en,
  input  logic        sub,
  output logic [31:0] y
);

  localparam logic signed [9:0] EInf = 10'(2 * FP_BIAS + 1);

  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic        s1_vld_q, s2_vld_q;
  logic [31:0] y_d, y_q;

  // ---------------- S1: unpack, classify, swap, align ----------------
  fp32_t       fa, fb;
  fp_class_t   ca, cb;
  logic        za, zb, a_big;
  logic [7:0]  ea, eb, e_big, e_sml, diff;
  logic [23:0] ma, mb, m_big, m_sml;
  logic [26:0] al, lost;

  always_comb begin
    fa      = a;
    fb      = b;
    fb.sign = b[31] ^ sub;
    ca      = classify(fa);
    cb      = classify(fb);
`ifdef FP_ADD_DENORM_EN
    za = ca.zero;
    zb = cb.zero;
    ea = ca.sub ? 8'd1 : fa.exp;
    eb = cb.sub ? 8'd1 : fb.exp;
    ma = {~(ca.zero | ca.sub), fa.frac};
    mb = {~(cb.zero | cb.sub), fb.frac};
`else
    za = ca.zero | ca.sub;
    zb = cb.zero | cb.sub;
    ea = za ? 8'd0 : fa.exp;
    eb = zb ? 8'd0 : fb.exp;
    ma = za ? 24'd0 : {1'b1, fa.frac};
    mb = zb ? 24'd0 : {1'b1, fb.frac};
`endif
    a_big = {ea, ma} >= {eb, mb};
    e_big = a_big ? ea : eb;
    e_sml = a_big ? eb : ea;
    m_big = a_big ? ma : mb;
    m_sml = a_big ? mb : ma;
    diff  = e_big - e_sml;
    if (diff > 8'd26) begin
      al   = 27'd0;
      lost = {26'd0, |m_sml};
    end else begin
      {al, lost} = {m_sml, 3'b000, 27'd0} >> diff;
    end

    s1_d         = '0;
    s1_d.nan     = ca.nan | cb.nan | (ca.inf & cb.inf & (fa.sign ^ fb.sign));
    s1_d.inf     = ca.inf | cb.inf;
    s1_d.zero    = za & zb;
    s1_d.eff_sub = fa.sign ^ fb.sign;
    s1_d.exp     = e_big;
    s1_d.ma      = {m_big, 3'b000};
    s1_d.mb      = {al[26:1], al[0] | (|lost)};
    if (ca.inf | cb.inf) s1_d.sign = ca.inf ? fa.sign : fb.sign;
    else if (za & zb)    s1_d.sign = fa.sign & fb.sign;
    else                 s1_d.sign = a_big ? fa.sign : fb.sign;
  end

  // ---------------- S2: add/subtract, count, normalize ----------------
  logic [27:0] sum, norm;
  logic [4:0]  lz, shamt;

  fp_lzc u_lzc (
    .in_i  (sum),
    .cnt_o (lz)
  );

  always_comb begin
    sum = s1_q.eff_sub ? ({1'b0, s1_q.ma} - {1'b0, s1_q.mb})
                       : ({1'b0, s1_q.ma} + {1'b0, s1_q.mb});
`ifdef FP_ADD_DENORM_EN
    // Stop normalizing at the minimum exponent so tiny results stay subnormal
    shamt = ({3'b000, lz} > s1_q.exp) ? s1_q.exp[4:0] : lz;
`else
    shamt = lz;
`endif
    norm = sum << shamt;

    s2_d      = '0;
    s2_d.nan  = s1_q.nan;
    s2_d.inf  = s1_q.inf;
    s2_d.zero = s1_q.zero | (sum == 28'd0);
    s2_d.sign = (!s1_q.zero && sum == 28'd0) ? 1'b0 : s1_q.sign;
    s2_d.exp  = 10'($signed({2'b00, s1_q.exp}) + 10'sd1 - $signed({5'b00000, shamt}));
    s2_d.mant = norm[27:4];
    s2_d.g    = norm[3];
    s2_d.st   = |norm[2:0];
  end

  // ---------------- S3: round, pack ----------------
  logic        inc;
  logic [7:0]  exp_f;
  logic [30:0] mag;
  logic [31:0] s3_res;

  always_comb begin
    inc   = s2_q.g & (s2_q.st | s2_q.mant[0]);
    exp_f = s2_q.mant[23] ? s2_q.exp[7:0] : 8'd0;
    // Carry out of the fraction bumps the exponent, covering renormalize and overflow
    mag   = {exp_f, s2_q.mant[22:0]} + {30'd0, inc};
    if (s2_q.nan)                       s3_res = FP_QNAN;
    else if (s2_q.inf)                  s3_res = {s2_q.sign, FP_PINF[30:0]};
    else if (s2_q.zero)                 s3_res = {s2_q.sign, 31'd0};
    else if ($signed(s2_q.exp) >= EInf) s3_res = {s2_q.sign, FP_PINF[30:0]};
`ifndef FP_ADD_DENORM_EN
    else if ($signed(s2_q.exp) < 10'sd1) s3_res = {s2_q.sign, 31'd0};
`endif
    else                                s3_res = {s2_q.sign, mag};
  end

  // ---------------- Extra delay stages and output register ----------------
  logic [31:0] fin_res;
  logic        fin_vld;

  if (LAT == 3) begin : g_nodly
    assign fin_res = s3_res;
    assign fin_vld = s2_vld_q;
  end else begin : g_dly
    logic [LAT-4:0][31:0] res_q;
    logic [LAT-4:0]       vld_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_q <= '0;
        vld_q <= '0;
      end else begin
        res_q[0] <= s3_res;
        vld_q[0] <= s2_vld_q;
        for (int k = 1; k < int'(LAT) - 3; k++) begin
          res_q[k] <= res_q[k-1];
          vld_q[k] <= vld_q[k-1];
        end
      end
    end
    assign fin_res = res_q[LAT-4];
    assign fin_vld = vld_q[LAT-4];
  end

  always_comb begin
    y_d = fin_vld ? fin_res : y_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      y_q      <= 32'd0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s1_vld_q <= en;
      s2_vld_q <= s1_vld_q;
      y_q      <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fp_add.sv
// Directed self-checking bench for fp_add; expectations are hand-computed binary32 values.
`ifndef FP_ADD_LAT
`define FP_ADD_LAT 3
`endif

module tb_fp_add;

  localparam int unsigned LAT = `FP_ADD_LAT;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        en;
  logic        sub;
  logic [31:0] y;

  int checks = 0;
  int errors = 0;

  fp_add #(.LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .en  (en),
    .sub (sub),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: y=%08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one op, confirm y still holds prev one cycle early, then the result on time
  task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                    input logic [31:0] exp, input logic [31:0] prev, input string tag);
    @(negedge clk);
    a   = av;
    b   = bv;
    sub = sv;
    en  = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    #1 check({tag, "_early"}, y, prev);
    @(posedge clk);
    #1 check(tag, y, exp);
  endtask

  logic [31:0] exp_uf, exp_sub_in;

  initial begin
`ifdef FP_ADD_DENORM_EN
    exp_uf     = 32'h00400000;
    exp_sub_in = 32'h00400000;
`else
    exp_uf     = 32'h00000000;
    exp_sub_in = 32'h00800000;
`endif
    rst = 1'b1;
    en  = 1'b0;
    sub = 1'b0;
    a   = 32'd0;
    b   = 32'd0;
    #1 check("reset", y, 32'h00000000);
    @(negedge clk);
    rst = 1'b0;

    op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 32'h00000000, "add_1_2");
    repeat (4) @(posedge clk);
    #1 check("hold", y, 32'h40400000);

    op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 32'h40400000, "sub_3_1");
    op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 32'h40000000, "cancel");
    op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 32'h00000000, "rne_tie");
    op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 32'h3F800000, "rne_up");
    op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 32'h3F800001, "inf_m_inf");
    op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 32'h7FC00000, "overflow");
    op(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 32'h7F800000, "nan_in");
    op(32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 32'h7FC00000, "neg_res");
    op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 32'hC0000000, "negzero");
    op(32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 32'h80000000, "inf_p_fin");
    op(32'h00C00000, 32'h00800000, 1'b1, exp_uf, 32'h7F800000, "underflow");
    op(32'h00800000, 32'h00400000, 1'b1, exp_sub_in, exp_uf, "sub_input");

    // Back-to-back stream: 1+1, 2+2, 3+3
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; en = 1'b1;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    a = 32'h40400000; b = 32'h40400000;
    @(negedge clk);
    en = 1'b0;
    check("stream0", y, 32'h40000000);
    @(posedge clk);
    #1 check("stream1", y, 32'h40800000);
    @(posedge clk);
    #1 check("stream2", y, 32'h40C00000);
    repeat (3) @(posedge clk);
    #1 check("stream_hold", y, 32'h40C00000);

    // Asynchronous reset with an op in flight
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst", y, 32'h00000000);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1 check("rst_drop", y, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
